// File: rtl/mp_array_pkg.sv
// Shared types and helpers for the multi-read-port cache state array.
// lane_merge works on a fixed maximum width; callers zero-extend and truncate.
package mp_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int unsigned MERGE_W     = 256;
  localparam int unsigned MERGE_IDX_W = 8;

  // Bit i takes new_val when the lane covering it (i / gran) is enabled.
  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0] old_val,
    input logic [MERGE_W-1:0] new_val,
    input logic [MERGE_W-1:0] mask,
    input int unsigned        gran
  );
    logic [MERGE_W-1:0] res;
    res = old_val;
    for (int unsigned i = 0; i < MERGE_W; i++) begin
      if (mask[MERGE_IDX_W'(i / gran)]) begin
        res[MERGE_IDX_W'(i)] = new_val[MERGE_IDX_W'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mp_array_clear_fsm.sv
// Flush sequencer: sweeps one set per cycle and deasserts ready while sweeping.
module mp_array_clear_fsm
  import mp_array_pkg::*;
#(
  parameter int unsigned S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  output logic               ready,
  output logic               clr_we,
  output logic [S_INDEX-1:0] clr_idx
);

  localparam logic [S_INDEX-1:0] LAST_IDX = {S_INDEX{1'b1}};

  clr_state_t         state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;

  // State, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready   <= 1'b1;
      clr_we  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= (state_d == IDLE);
      clr_we  <= (state_d == CLEAR);
    end
  end

  assign clr_idx = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Counter wraps to zero exactly as the sweep finishes.
        cnt_d = S_INDEX'(cnt_q + 1'b1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mp_array.sv
// Multi-read-port register array with masked writes, write-to-read bypass
// and a sequenced flush engine. WIDTH must not exceed mp_array_pkg::MERGE_W.
module mp_array
  import mp_array_pkg::*;
#(
  parameter int unsigned S_INDEX    = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned MASK_GRAN  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RPORTS-1:0]         read,
  input  logic [NUM_RPORTS*S_INDEX-1:0] rindex,
  output logic [NUM_RPORTS*WIDTH-1:0]   dataout,
  input  logic                          load,
  input  logic [S_INDEX-1:0]            windex,
  input  logic [WIDTH/MASK_GRAN-1:0]    wmask,
  input  logic [WIDTH-1:0]              datain,
  input  logic                          clear,
  output logic                          ready
);

  localparam int unsigned NUM_SETS  = 2 ** S_INDEX;
  localparam int unsigned NUM_LANES = WIDTH / MASK_GRAN;

  logic [WIDTH-1:0]   mem [NUM_SETS];
  logic               clr_we;
  logic [S_INDEX-1:0] clr_idx;
  logic               wr_en_c;
  logic [WIDTH-1:0]   merged_c;

  mp_array_clear_fsm #(
    .S_INDEX (S_INDEX)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_en_c  = load && ready;
  assign merged_c = WIDTH'(lane_merge(MERGE_W'(mem[windex]), MERGE_W'(datain),
                                      MERGE_W'(wmask), MASK_GRAN));

  // Storage: reset clears everything, sweep has priority over normal writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        mem[S_INDEX'(s)] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_en_c) begin
      mem[windex] <= merged_c;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [S_INDEX-1:0] ridx;
    logic [WIDTH-1:0]   rd_q;

    assign ridx = rindex[p*S_INDEX +: S_INDEX];

    // Same-cycle write to the read index forwards the post-write entry value.
    always_ff @(posedge clk) begin
      if (!rst) begin
        rd_q <= '0;
      end else if (read[p] && ready) begin
        if (wr_en_c && (ridx == windex)) begin
          rd_q <= merged_c;
        end else begin
          rd_q <= mem[ridx];
        end
      end
    end

    assign dataout[p*WIDTH +: WIDTH] = rd_q;
  end

  if (NUM_LANES * MASK_GRAN != WIDTH) begin : g_bad_gran
    $error("mp_array: WIDTH must be a multiple of MASK_GRAN");
  end

endmodule
